// File: rtl/spi_sample_rx.sv
// SPI mode-0 receiver that deserialises one 2*SAMPLE_W-bit frame into two player samples.
// Optional sdo read-back of the previous frame when SPI_SAMPLE_ECHO_EN is defined.
module spi_sample_rx #(
  parameter int SAMPLE_W    = 12,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic                sdi,
  output logic                sdo,
  output logic [SAMPLE_W-1:0] p1data,
  output logic [SAMPLE_W-1:0] p2data,
  output logic                valid,
  output logic                frame_err,
  output logic [ERR_W-1:0]    err_count
);

  localparam int F  = 2 * SAMPLE_W;
  localparam int CW = $clog2(F) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(F);
  localparam logic [CW-1:0] CNT_SAT  = CW'(F + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sclk_s, cs_s, sdi_s;
  logic sclk_d, cs_d;
  logic sclk_q, cs_q, sdi_q;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [F-1:0]  shreg;
  logic [CW-1:0] cnt;

  // Chains reset low so cs_n reads "not idle" until the pin is genuinely seen high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s <= '0;
      cs_s   <= '0;
      sdi_s  <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      cs_s   <= {cs_s[SYNC_STAGES-2:0], cs_n};
      sdi_s  <= {sdi_s[SYNC_STAGES-2:0], sdi};
      sclk_d <= sclk_q;
      cs_d   <= cs_q;
    end
  end

  assign sclk_q    = sclk_s[SYNC_STAGES-1];
  assign cs_q      = cs_s[SYNC_STAGES-1];
  assign sdi_q     = sdi_s[SYNC_STAGES-1];
  assign sclk_rise = sclk_q & ~sclk_d;
  assign sclk_fall = ~sclk_q & sclk_d;
  assign cs_rise   = cs_q & ~cs_d;
  assign cs_fall   = ~cs_q & cs_d;

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      WAIT_IDLE: if (cs_q)    state_nx = IDLE;
      IDLE:      if (cs_fall) state_nx = SHIFT;
      SHIFT:     if (cs_rise) state_nx = COMMIT;
      COMMIT:                 state_nx = IDLE;
      default:                state_nx = WAIT_IDLE;
    endcase
  end

  // Results are registered on the SHIFT->COMMIT transition so they are visible
  // exactly during the single COMMIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      cnt       <= '0;
      p1data    <= '0;
      p2data    <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE && cs_fall) begin
        shreg <= '0;
        cnt   <= '0;
      end
      if (state == SHIFT) begin
        if (cs_rise) begin
          if (cnt == CNT_FULL) begin
            p1data <= shreg[F-1:SAMPLE_W];
            p2data <= shreg[SAMPLE_W-1:0];
            valid  <= 1'b1;
          end else begin
            frame_err <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
          end
        end else if (sclk_rise) begin
          shreg <= {shreg[F-2:0], sdi_q};
          if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef SPI_SAMPLE_ECHO_EN
  logic [F-1:0] echo;

  always_ff @(posedge clk) begin
    if (reset)                          echo <= '0;
    else if (state == IDLE && cs_fall)  echo <= {p1data, p2data};
    else if (state == SHIFT && sclk_fall) echo <= {echo[F-2:0], 1'b0};
  end

  assign sdo = (state == SHIFT) & echo[F-1];
`else
  assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sample_rx.sv
// Randomised self-checking bench for spi_sample_rx against a frame-level reference model.
module tb_spi_sample_rx;
  localparam int SW = 12;
  localparam int F  = 2 * SW;

  logic clk = 1'b0, reset = 1'b1, sclk = 1'b0, cs_n = 1'b1, sdi = 1'b0;
  logic sdo, valid, frame_err;
  logic [SW-1:0] p1data, p2data;
  logic [7:0] err_count;

  spi_sample_rx dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .sdi(sdi), .sdo(sdo),
    .p1data(p1data), .p2data(p2data), .valid(valid), .frame_err(frame_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int ntests = 0, nfail = 0;
  int vcnt = 0, ecnt = 0, unstable = 0;
  logic [SW-1:0] p1_prev = '0, p2_prev = '0;

  // reference state
  logic [SW-1:0] mp1 = '0, mp2 = '0;
  int merr = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (valid)     vcnt <= vcnt + 1;
      if (frame_err) ecnt <= ecnt + 1;
      if ((p1data != p1_prev || p2data != p2_prev) && !valid) unstable <= unstable + 1;
    end
    p1_prev <= p1data;
    p2_prev <= p2data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic so);
    sdi = b;
    wclk(4);
    so = sdo;
    sclk = 1'b1;
    wclk(4);
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input int n, input logic [63:0] d, output logic [63:0] so);
    logic b;
    so = '0;
    cs_n = 1'b0;
    wclk(6);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(d[i], b);
      so = {so[62:0], b};
    end
    wclk(4);
    cs_n = 1'b1;
    wclk(8);
  endtask

  // Sends a frame and checks the outcome against the frame-level rules.
  task automatic frame_chk(input string tag, input int n, input logic [63:0] d);
    int v0, e0, ev, ee;
    logic [63:0] so;
    v0 = vcnt; e0 = ecnt;
    spi_frame(n, d, so);
    if (n == F) begin
      mp1 = d[F-1:SW]; mp2 = d[SW-1:0]; ev = 1; ee = 0;
    end else begin
      if (merr < 255) merr++;
      ev = 0; ee = 1;
    end
    chk({tag, "_valid"}, vcnt - v0, ev);
    chk({tag, "_ferr"}, ecnt - e0, ee);
    chk({tag, "_p1"}, p1data, mp1);
    chk({tag, "_p2"}, p2data, mp2);
    chk({tag, "_errcnt"}, err_count, merr);
  endtask

  initial begin
    logic [63:0] so;
    logic [63:0] d;
    logic b;
    int v0, e0, n;

    wclk(4);
    chk("rst_p1", p1data, 0);
    chk("rst_p2", p2data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_sdo", sdo, 0);
    reset = 1'b0;
    wclk(6);

    frame_chk("good1", 24, 64'hABC123);
    frame_chk("short23", 23, 64'h7FFFFF);
    frame_chk("long30", 30, 64'h2AAAAAAA);
    frame_chk("good2", 24, 64'hFFF000);

    // reset with cs_n low mid-frame; the tail of that frame must be ignored
    v0 = vcnt; e0 = ecnt;
    cs_n = 1'b0;
    wclk(6);
    for (int i = 0; i < 10; i++) send_bit(i[0], b);
    reset = 1'b1;
    wclk(3);
    reset = 1'b0;
    mp1 = '0; mp2 = '0; merr = 0;
    for (int i = 0; i < 14; i++) send_bit(~i[0], b);
    wclk(4);
    cs_n = 1'b1;
    wclk(8);
    chk("midrst_valid", vcnt - v0, 0);
    chk("midrst_ferr", ecnt - e0, 0);
    chk("midrst_p1", p1data, 0);
    chk("midrst_errcnt", err_count, 0);
    frame_chk("after_rst", 24, 64'h001800);

    // sclk toggling with cs_n high
    v0 = vcnt; e0 = ecnt;
    for (int i = 0; i < 24; i++) begin
      sdi = 1'($urandom);
      wclk(4); sclk = 1'b1; wclk(4); sclk = 1'b0;
    end
    wclk(8);
    chk("idle_valid", vcnt - v0, 0);
    chk("idle_ferr", ecnt - e0, 0);

    for (int i = 0; i < 258; i++) begin
      n = $urandom_range(1, 4);
      spi_frame(n, 64'($urandom), so);
      if (merr < 255) merr++;
    end
    chk("sat_errcnt", err_count, merr);
    chk("sat_ff", err_count, 8'hFF);
    frame_chk("sat_more", 3, 64'h5);

    // echo read-back of the previously accepted frame
    frame_chk("echo_src", 24, 64'h5A53C3);
    v0 = vcnt;
    d = {32'h0, $urandom} & 64'hFFFFFF;
    spi_frame(24, d, so);
    mp1 = d[F-1:SW]; mp2 = d[SW-1:0];
    chk("echo_valid", vcnt - v0, 1);
`ifdef SPI_SAMPLE_ECHO_EN
    chk("echo_sdo", so[31:0], 32'h5A53C3);
`else
    chk("echo_sdo", so[31:0], 32'h0);
`endif

    for (int k = 0; k < 20; k++) begin
      n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 35) : F;
      d = {$urandom, $urandom};
      frame_chk("rand", n, d);
    end

    chk("stable", unstable, 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
